// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, result and status signals of the shared ALU arbiter
interface alu_share_arbiter_if #(
    parameter int WIDTH = 5
);
    // Requester 0
    logic             req_0;
    logic [1:0]       op_0;
    logic [WIDTH-1:0] a_0;
    logic [WIDTH-1:0] b_0;
    logic             gnt_0;

    // Requester 1
    logic             req_1;
    logic [1:0]       op_1;
    logic [WIDTH-1:0] a_1;
    logic [WIDTH-1:0] b_1;
    logic             gnt_1;

    // Result towards the consumer
    logic [WIDTH-1:0] out_data;
    logic             out_id;
    logic             out_valid;
    logic             out_ready;

    // Status
    logic             busy;

    // Client side: requesters and the result consumer
    modport master (
        output req_0, op_0, a_0, b_0,
        output req_1, op_1, a_1, b_1,
        output out_ready,
        input  gnt_0, gnt_1,
        input  out_data, out_id, out_valid,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  req_0, op_0, a_0, b_0,
        input  req_1, op_1, a_1, b_1,
        input  out_ready,
        output gnt_0, gnt_1,
        output out_data, out_id, out_valid,
        output busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one AND/OR/ADD unit between two requesters
module alu_share_arbiter #(
    parameter int WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_share_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q,      state_d;
    logic             last_id_q,    last_id_d;
    logic             cur_id_q,     cur_id_d;
    logic [1:0]       op_q,         op_d;
    logic [WIDTH-1:0] a_q,          a_d;
    logic [WIDTH-1:0] b_q,          b_d;
    logic             gnt_0_q,      gnt_0_d;
    logic             gnt_1_q,      gnt_1_d;
    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic             out_id_q,     out_id_d;
    logic             out_valid_q,  out_valid_d;
    logic             busy_q,       busy_d;

    logic             any_req;
    logic             win_id;

    // Shared datapath; every result wraps modulo 2^WIDTH, carries are dropped.
    function automatic logic [WIDTH-1:0] alu_f(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] and_v;
        logic [WIDTH-1:0] or_v;
        and_v = a & b;
        or_v  = a | b;
        case (op)
            2'b00:   alu_f = and_v;
            2'b01:   alu_f = or_v;
            2'b10:   alu_f = a + b;
            default: alu_f = or_v & (and_v + or_v);
        endcase
    endfunction

    // Winner selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        any_req = bus.req_0 | bus.req_1;
        if (bus.req_0 && bus.req_1) begin
            win_id = ~last_id_q;
        end else begin
            win_id = bus.req_1;
        end
    end

    // Next-state and registered-output logic of the IDLE/EXEC/HOLD sequencer.
    always_comb begin
        state_d     = state_q;
        last_id_d   = last_id_q;
        cur_id_d    = cur_id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        gnt_0_d     = 1'b0;
        gnt_1_d     = 1'b0;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    cur_id_d  = win_id;
                    last_id_d = win_id;
                    op_d      = win_id ? bus.op_1 : bus.op_0;
                    a_d       = win_id ? bus.a_1  : bus.a_0;
                    b_d       = win_id ? bus.b_1  : bus.b_0;
                    gnt_0_d   = ~win_id;
                    gnt_1_d   = win_id;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                out_data_d  = alu_f(op_q, a_q, b_q);
                out_id_d    = cur_id_q;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                // Result and owner stay put until the consumer takes them;
                // out_data is deliberately left holding the last value.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_id_q   <= 1'b1;
            cur_id_q    <= 1'b0;
            op_q        <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            gnt_0_q     <= 1'b0;
            gnt_1_q     <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_id_q   <= last_id_d;
            cur_id_q    <= cur_id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gnt_0_q     <= gnt_0_d;
            gnt_1_q     <= gnt_1_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt_0     = gnt_0_q;
    assign bus.gnt_1     = gnt_1_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 5-bit logic/add unit between two requesters.
- Operation set matches the team's AND/OR/ADD datapath: AND, OR, ADD, and the combined function (a|b) & ((a&b)+(a|b)).
- Sits between two client blocks and a single result consumer.
- Grants one requester at a time, captures its operands, computes the result, and holds it under consumer backpressure.

Parameters:
- WIDTH, 5, operand/result width in bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- req_0  input  1  requester 0 request.
- op_0  input  2  requester 0 opcode.
- a_0  input  WIDTH  requester 0 operand a.
- b_0  input  WIDTH  requester 0 operand b.
- gnt_0  output  1  one-cycle grant pulse to requester 0.
- req_1, op_1, a_1, b_1, gnt_1  same as requester 0, for requester 1.
- out_data  output  WIDTH  result.
- out_id  output  1  index of the requester that owns out_data.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: rst_n=0 sampled at an edge gives state=IDLE, gnt_0=gnt_1=0, out_valid=0, out_data=0, out_id=0, busy=0, last_id=1 (requester 0 wins the first tie).
- Reset mid-operation: the in-flight op is dropped and no out_valid is produced.
- All outputs are registered.
- FSM states: IDLE, EXEC, HOLD.
- IDLE, no request: stay in IDLE.
- IDLE, any request at edge E0:
  - Select winner: the only requester, or on a tie the one != last_id.
  - Capture winner's op/a/b.
  - last_id <= winner.
  - gnt_winner=1 for exactly the cycle after E0.
  - Next state EXEC.
- EXEC at edge E1:
  - out_data <= f(op, a, b); out_id <= winner; out_valid <= 1.
  - Next state HOLD.
- HOLD:
  - out_data, out_id and out_valid stay stable while out_ready=0.
  - At an edge with out_ready=1: out_valid <= 0, next state IDLE.
  - out_data keeps its last value after out_valid drops.
- Latency and throughput:
  - Request sample to out_valid is 2 edges.
  - Minimum spacing between grants is 3 cycles.
- Requests are not sampled in EXEC or HOLD; a pending request waits.
- Request protocol:
  - Requester holds req, op, a, b stable until it sees gnt.
  - Requester drops req in the gnt cycle.
  - A req still high at the next IDLE edge is a new request.
- Opcode f(op, a, b), all results truncated to WIDTH (carry discarded, mod 2^WIDTH):
  - 00: a & b.
  - 01: a | b.
  - 10: a + b.
  - 11: (a|b) & ((a&b) + (a|b)).
- Fairness: two continuously asserted requesters alternate grants 0,1,0,1...
- Simultaneous events: a new request arriving in the same cycle as the HOLD handshake is not granted until the following IDLE edge.

Test Plan:
- Reset check: rst_n=0 for 2 cycles with req_0=req_1=1 -> gnt_0=gnt_1=0, out_valid=0, busy=0 throughout.
- Single requester: req_0=1, a_0=22, b_0=13, out_ready=1. Ops 00, 01, 10, 11 in turn -> out_data 4, 31, 3, 3; out_id=0; out_valid exactly 2 edges after request sample.
- Tie after reset: req_0 and req_1 asserted the same cycle, a=3, b=5, op_1=11, op_0=10 -> gnt_0 first with result 8; then gnt_1 with result 0 and out_id=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data/out_id stable; no grant despite req_1=1; out_ready=1 gives one handshake, then IDLE, then gnt_1.
- Continuous requests from both for 8 grants -> grant order 0,1,0,1,0,1,0,1; no gnt_0 and gnt_1 in the same cycle.
- Reset in EXEC: assert rst_n=0 one cycle after gnt_0 -> out_valid never rises, state IDLE; next req_1 is granted normally with last_id logic restarted (tie goes to 0).
